ipml_reg_fifo_v2_0: RTL
=======================

Name: ipml_reg_fifo_v2_0

Overview:
- Parametrised register-based valid/ready FIFO; generalises the fixed depth-2 output stage used behind prefetch FIFOs to any depth 1..16.
- Adds a level output, almost-full/almost-empty flags, a synchronous flush and an optional ready pass-through mode.
- Sits between a RAM-based FIFO read port, or any streaming source, and a consumer in the same clock domain.

Parameters:
- W, 32, data width in bits, 1..1152.
- DEPTH, 2, number of entries, 1..16; non-power-of-two values are legal.
- AFULL_TH, DEPTH-1, almost_full asserts when level >= AFULL_TH; legal range 1..DEPTH.
- AEMPTY_TH, 1, almost_empty asserts when level <= AEMPTY_TH; legal range 0..DEPTH-1.
- READY_PASS, 0, 0 = data_in_ready is registered-state only; 1 = data_in_ready is also high when full and data_out_ready=1.
- LW, clog2(DEPTH+1), level width (derived localparam).

Ports:
- clk, input, 1, single clock, rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- flush, input, 1, synchronous clear of all entries.
- data_in_valid, input, 1, source has data.
- data_in, input, W, write data.
- data_in_ready, output, 1, FIFO accepts data this cycle.
- data_out_ready, input, 1, sink accepts data.
- data_out, output, W, head entry.
- data_out_valid, output, 1, head entry is valid.
- level, output, LW, number of stored entries, 0..DEPTH.
- almost_full, output, 1, level >= AFULL_TH.
- almost_empty, output, 1, level <= AEMPTY_TH.
- overflow, output, 1, one-cycle pulse: data_in_valid=1 while data_in_ready=0.

Behaviour:
- Reset (rst_n=0, async assert, clock-synchronous release):
  - wr_ptr=0, rd_ptr=0, level=0.
  - data_out_valid=0, data_in_ready=1, almost_full=0 (AFULL_TH >= 1), almost_empty=1, overflow=0.
  - Storage array is not reset; data_out is don't-care while data_out_valid=0.
- push = data_in_valid & data_in_ready; pop = data_out_valid & data_out_ready.
- Storage:
  - Register array of DEPTH x W.
  - wr_ptr and rd_ptr each wrap from DEPTH-1 to 0 by explicit compare, not power-of-two masking.
  - push writes data_in at wr_ptr; pop advances rd_ptr.
- Level update:
  - push only: +1. pop only: -1. Both or neither: unchanged.
  - Level never exceeds DEPTH and never goes below 0.
- data_out = mem[rd_ptr]; data_out_valid = (level != 0). Both are driven from registered state only, with no combinational path from data_in.
- Latency: a push in cycle N is visible on data_out/data_out_valid in cycle N+1, including when empty (no bypass).
- data_in_ready:
  - READY_PASS=0: (level != DEPTH).
  - READY_PASS=1: (level != DEPTH) | data_out_ready. When full with pop and push in the same cycle, the freed slot is written and level stays at DEPTH.
- Empty with data_out_ready=1: no pop occurs; level stays at 0 and there is no underflow.
- Flags are registered, computed from the next level value, so they are coincident with level.
- flush:
  - Next cycle: pointers and level = 0, data_out_valid=0.
  - A push or pop in the flush cycle is discarded.
  - data_in_ready is unaffected in the flush cycle.
- overflow is a registered pulse, asserted the cycle after the violation; the FIFO contents are unchanged by a rejected write.
- Hold rule: data_out must stay stable while data_out_valid=1 and data_out_ready=0.
- DEPTH=1: behaves as a single full/empty register. READY_PASS=1 then gives full throughput; READY_PASS=0 gives half throughput.

Decomposition:
- Shared package ipml_fifo_pkg:
  - clog2 function.
  - Pointer-increment-with-wrap function.
  - Legality-check constants (max DEPTH 16, max W 1152).
- One natural sub-module: ipml_fifo_lvl_flags, which computes the next-level value and the registered almost_full/almost_empty flags. It is reusable by the RAM-based FIFOs.
- Storage and pointers stay in the top module.

Test Plan:
- Reset and fill, DEPTH=4, READY_PASS=0, sink stalled: push 0xA0..0xA4 on consecutive cycles. Expect data_in_ready low after 4 pushes, level=4, almost_full=1 from level 3, overflow pulse for 0xA4, contents unchanged.
- Drain order: after the fill, hold data_out_ready=1. Expect data_out sequence 0xA0, 0xA1, 0xA2, 0xA3 on consecutive cycles, then data_out_valid=0, level=0, almost_empty=1.
- Full-throughput, DEPTH=1, READY_PASS=1: continuous valid/ready for 10 beats. Expect 10 outputs in 11 cycles and level never exceeding 1. Repeat with READY_PASS=0: expect one beat per 2 cycles.
- Non-power-of-two wrap, DEPTH=3: 20 random-gap push/pop beats. Scoreboard must match and the pointers must wrap 2 -> 0 with no duplication or loss.
- Flush mid-stream, DEPTH=4: level=3 and flush asserted concurrently with push 0x55 and pop. Next cycle expect level=0, data_out_valid=0, and 0x55 never emitted.
- Async reset mid-operation: drop rst_n asynchronously with level=2. Immediately expect data_out_valid=0, level=0, data_in_ready=1. After release, a push followed by a pop returns the new data.

Source files
------------

// File: rtl/ipml_fifo_pkg.sv
// Shared helpers for the ipml FIFO family: width math, pointer wrap and legal parameter limits.
package ipml_fifo_pkg;

   localparam int unsigned MAX_DEPTH = 16;
   localparam int unsigned MAX_W     = 1152;

   function automatic int unsigned clog2(input int unsigned v);
      int unsigned r;
      r = 0;
      while ((32'd1 << r) < v) r = r + 1;
      return r;
   endfunction

   // Pointer wrap is an explicit compare so non-power-of-two depths work.
   function automatic int unsigned ptr_inc(input int unsigned p, input int unsigned depth);
      return (p >= depth - 1) ? 0 : p + 1;
   endfunction

endpackage

// File: rtl/ipml_fifo_lvl_flags.sv
// FIFO occupancy counter with registered almost-full/almost-empty flags derived from the next level.
module ipml_fifo_lvl_flags
   import ipml_fifo_pkg::*;
#(
   parameter int unsigned DEPTH     = 2,
   parameter int unsigned AFULL_TH  = 1,
   parameter int unsigned AEMPTY_TH = 1,
   parameter int unsigned LW        = 2
)(
   input  logic          clk,
   input  logic          rst_n,
   input  logic          flush,
   input  logic          push,
   input  logic          pop,
   output logic [LW-1:0] level,
   output logic          almost_full,
   output logic          almost_empty
);

   localparam logic [LW-1:0] AF_TH = LW'(AFULL_TH);
   localparam logic [LW-1:0] AE_TH = LW'(AEMPTY_TH);

   logic [LW-1:0] level_nxt;

   always_comb begin
      level_nxt = level;
      if (flush)
         level_nxt = '0;
      else if (push && !pop)
         level_nxt = level + 1'b1;
      else if (pop && !push)
         level_nxt = level - 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         level        <= '0;
         almost_full  <= 1'b0;
         almost_empty <= 1'b1;
      end else begin
         level        <= level_nxt;
         almost_full  <= (level_nxt >= AF_TH);
         almost_empty <= (level_nxt <= AE_TH);
      end
   end

endmodule

// File: rtl/ipml_reg_fifo_v2_0.sv
// Register-based valid/ready FIFO of 1..16 entries with level, almost flags, flush and optional ready pass-through.
module ipml_reg_fifo_v2_0
   import ipml_fifo_pkg::*;
#(
   parameter  int unsigned W          = 32,
   parameter  int unsigned DEPTH      = 2,
   parameter  int unsigned AFULL_TH   = DEPTH - 1,
   parameter  int unsigned AEMPTY_TH  = 1,
   parameter  int unsigned READY_PASS = 0,
   localparam int unsigned LW         = clog2(DEPTH + 1)
)(
   input  logic          clk,
   input  logic          rst_n,
   input  logic          flush,
   input  logic          data_in_valid,
   input  logic [W-1:0]  data_in,
   output logic          data_in_ready,
   input  logic          data_out_ready,
   output logic [W-1:0]  data_out,
   output logic          data_out_valid,
   output logic [LW-1:0] level,
   output logic          almost_full,
   output logic          almost_empty,
   output logic          overflow
);

   localparam int unsigned PW = (DEPTH > 1) ? clog2(DEPTH) : 1;

   logic [W-1:0]  mem [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic          full;
   logic          push;
   logic          pop;

   assign full           = (level == LW'(DEPTH));
   assign data_in_ready  = (READY_PASS != 0) ? (~full | data_out_ready) : ~full;
   assign data_out_valid = (level != '0);
   assign data_out       = mem[rd_ptr];
   assign push           = data_in_valid & data_in_ready;
   assign pop            = data_out_valid & data_out_ready;

   // When full with pass-through, wr_ptr == rd_ptr: the head is read out this cycle and its slot refilled.
   always_ff @(posedge clk) begin
      if (push && !flush)
         mem[wr_ptr] <= data_in;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         overflow <= 1'b0;
      end else begin
         overflow <= data_in_valid & ~data_in_ready;
         if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
         end else begin
            if (push)
               wr_ptr <= PW'(ptr_inc(32'(wr_ptr), DEPTH));
            if (pop)
               rd_ptr <= PW'(ptr_inc(32'(rd_ptr), DEPTH));
         end
      end
   end

   ipml_fifo_lvl_flags #(
      .DEPTH     (DEPTH),
      .AFULL_TH  (AFULL_TH),
      .AEMPTY_TH (AEMPTY_TH),
      .LW        (LW)
   ) u_lvl (
      .clk          (clk),
      .rst_n        (rst_n),
      .flush        (flush),
      .push         (push),
      .pop          (pop),
      .level        (level),
      .almost_full  (almost_full),
      .almost_empty (almost_empty)
   );

endmodule
